sys_cmd_ctrl: RTL
=================

SYS_CMD_CTRL -- requirements
Module: sys_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the UART byte and register-file data.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the register-file address width.
REQ-003 CLK  in  1  SHALL be the single clock; all state SHALL change on rising edge only.
REQ-004 RST  in  1  SHALL be a synchronous, active-high reset.
REQ-005 RX_P_DATA  in  DATA_WIDTH  SHALL carry a received command byte, valid when RX_D_VLD=1.
REQ-006 RX_D_VLD  in  1  SHALL be a one-cycle strobe, one per received byte.
REQ-007 RF_RD_DATA  in  DATA_WIDTH  SHALL carry read data, valid when RF_RD_DATA_VLD=1.
REQ-008 RF_RD_DATA_VLD  in  1  SHALL be the register-file read-data strobe.
REQ-009 ALU_OUT  in  2*DATA_WIDTH  SHALL carry the ALU result, valid when ALU_OUT_VLD=1.
REQ-010 ALU_OUT_VLD  in  1  SHALL be the ALU result strobe.
REQ-011 TX_BUSY  in  1  SHALL be high while the UART transmitter is sending.
REQ-012 RF_ADDR  out  ADDR_WIDTH  SHALL be the register-file address.
REQ-013 RF_WR_EN / RF_RD_EN  out  1 each  SHALL be the register-file write and read strobes.
REQ-014 RF_WR_DATA  out  DATA_WIDTH  SHALL be the register-file write data.
REQ-015 ALU_EN  out  1; ALU_FUN  out  4; CLK_GATE_EN  out  1  SHALL form the ALU start strobe, function code and clock-gate enable.
REQ-016 TX_P_DATA  out  DATA_WIDTH; TX_D_VLD  out  1  SHALL form the response byte and its request.

Function
REQ-017 The FSM SHALL have the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI and TX_RD.
REQ-018 In IDLE, an RX byte SHALL select the next state: 0xAA to WR_ADDR, 0xBB to RD_ADDR, 0xCC to ALU_A, 0xDD to ALU_FUN; any other byte SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-019 WR_ADDR SHALL latch RX_P_DATA[ADDR_WIDTH-1:0] as RF_ADDR; WR_DATA SHALL, on the byte, pulse RF_WR_EN for 1 cycle with RF_WR_DATA set to the byte, then go to IDLE.
REQ-020 RD_ADDR SHALL, on the byte, set RF_ADDR and pulse RF_RD_EN for 1 cycle, then go to RD_WAIT.
REQ-021 RD_WAIT SHALL, on RF_RD_DATA_VLD, capture RF_RD_DATA into the TX buffer and go to TX_RD.
REQ-022 ALU_A SHALL, on the byte, write it to RF address 0 (1-cycle RF_WR_EN); ALU_B SHALL write its byte to RF address 1; the FSM SHALL then go to ALU_FUN.
REQ-023 ALU_FUN SHALL, on the byte, set ALU_FUN to byte[3:0], pulse ALU_EN for 1 cycle, and go to ALU_WAIT.
REQ-024 CLK_GATE_EN SHALL be high from entry to ALU_A or ALU_FUN until ALU_OUT_VLD is captured.
REQ-025 ALU_WAIT SHALL, on ALU_OUT_VLD, capture the 16-bit result and go to TX_LO.
REQ-026 TX handshake: a TX state SHALL wait for TX_BUSY=0, then drive TX_P_DATA and raise TX_D_VLD; it SHALL hold both until TX_BUSY=1 is sampled, then drop TX_D_VLD and advance.
REQ-027 TX_LO SHALL send the result bits [7:0], then go to TX_HI; TX_HI SHALL send bits [15:8], then go to IDLE; TX_RD SHALL send the read byte, then go to IDLE.
REQ-028 RX bytes arriving in any wait or TX state SHALL be dropped.
REQ-029 TX_P_DATA SHALL stay stable while TX_D_VLD=1.
REQ-030 An RX_D_VLD coinciding with RF_RD_DATA_VLD or ALU_OUT_VLD SHALL be dropped; the completion SHALL be served.
REQ-031 Strobe outputs SHALL never be high for more than 1 consecutive cycle, except TX_D_VLD.

Reset
REQ-032 RST=1 at a clock edge SHALL force IDLE and all outputs to 0, including in the middle of a command or a TX handshake.
REQ-033 After reset, the FSM SHALL require a fresh command byte; partial commands SHALL be discarded.

Verification
REQ-034 Write: bytes 0xAA, 0x05, 0x7E -> one RF_WR_EN pulse with RF_ADDR=5 and RF_WR_DATA=0x7E; no TX_D_VLD.
REQ-035 Read: bytes 0xBB, 0x03 -> RF_RD_EN pulse with RF_ADDR=3; then RF_RD_DATA=0x7E -> TX_D_VLD with TX_P_DATA=0x7E, held until TX_BUSY=1.
REQ-036 ALU with operands: bytes 0xCC, 0xFF, 0x0F, 0x01 -> writes (0,0xFF) and (1,0x0F), then ALU_EN with ALU_FUN=1; ALU_OUT=0x010E -> TX 0x0E, then 0x01.
REQ-037 ALU without operands: bytes 0xDD, 0x02 -> no RF write, ALU_EN with ALU_FUN=2; the second TX byte SHALL wait while TX_BUSY=1.
REQ-038 Unknown byte 0x55 in IDLE -> no outputs; RST asserted after 0xAA, 0x05 -> IDLE, and a following byte 0x7E SHALL be ignored.

Source files
------------

// File: rtl/sys_cmd_ctrl_if.sv
// Command-controller bus bundle.
// Groups the UART RX/TX, register-file and ALU handshake signals of
// sys_cmd_ctrl. The clock and reset stay outside as plain ports.
//   master : controller side (drives RF_*, ALU_*, CLK_GATE_EN, TX_*)
//   slave  : environment side (drives RX_*, RF_RD_DATA*, ALU_OUT*, TX_BUSY)
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  // UART receive side
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  // register-file read return
  logic [DATA_WIDTH-1:0]   RF_RD_DATA;
  logic                    RF_RD_DATA_VLD;
  // ALU result return
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  // UART transmitter status
  logic                    TX_BUSY;

  // register-file access
  logic [ADDR_WIDTH-1:0]   RF_ADDR;
  logic                    RF_WR_EN;
  logic                    RF_RD_EN;
  logic [DATA_WIDTH-1:0]   RF_WR_DATA;
  // ALU control
  logic                    ALU_EN;
  logic [3:0]              ALU_FUN;
  logic                    CLK_GATE_EN;
  // UART transmit request
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD,
           ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA,
           ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD,
           ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA,
           ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// System command controller.
// Decodes UART command frames into register-file writes/reads and ALU
// operations, and returns read data / ALU results over the UART TX port.
//   0xAA addr data        : register write
//   0xBB addr             : register read, read byte sent back
//   0xCC opA opB fun      : write operands to RF[0]/RF[1], run ALU, send result LSB then MSB
//   0xDD fun              : run ALU on current operands, send result LSB then MSB
// Ports:
//   CLK  : single clock, rising edge
//   RST  : synchronous active-high reset (IDLE, all outputs 0)
//   bus  : sys_cmd_ctrl_if master modport (RX, RF, ALU, TX signals)
// All outputs are registered. RF_WR_EN, RF_RD_EN and ALU_EN are single-cycle
// strobes; TX_D_VLD is held until the transmitter reports busy.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  sys_cmd_ctrl_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_LO,
    S_TX_HI,
    S_TX_RD
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   rf_addr_q;
  logic                    rf_wr_en_q;
  logic                    rf_rd_en_q;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q;
  logic                    alu_en_q;
  logic [3:0]              alu_fun_q;
  logic                    clk_gate_en_q;
  logic [DATA_WIDTH-1:0]   tx_p_data_q;
  logic                    tx_d_vld_q;
  logic [DATA_WIDTH-1:0]   rd_buf_q;
  logic [2*DATA_WIDTH-1:0] alu_res_q;

  // Byte offered by whichever TX state is active.
  logic [DATA_WIDTH-1:0]   tx_byte;

  always_comb begin
    tx_byte = rd_buf_q;
    if (state_q == S_TX_LO) begin
      tx_byte = alu_res_q[DATA_WIDTH-1:0];
    end else if (state_q == S_TX_HI) begin
      tx_byte = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      rf_addr_q     <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_p_data_q   <= '0;
      tx_d_vld_q    <= 1'b0;
      rd_buf_q      <= '0;
      alu_res_q     <= '0;
    end else begin
      rf_wr_en_q <= 1'b0;
      rf_rd_en_q <= 1'b0;
      alu_en_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.RX_D_VLD) begin
            if (bus.RX_P_DATA == CMD_WR) begin
              state_q <= S_WR_ADDR;
            end else if (bus.RX_P_DATA == CMD_RD) begin
              state_q <= S_RD_ADDR;
            end else if (bus.RX_P_DATA == CMD_ALU_OP) begin
              state_q       <= S_ALU_A;
              clk_gate_en_q <= 1'b1;
            end else if (bus.RX_P_DATA == CMD_ALU) begin
              state_q       <= S_ALU_FUN;
              clk_gate_en_q <= 1'b1;
            end
          end
        end

        S_WR_ADDR: begin
          if (bus.RX_D_VLD) begin
            rf_addr_q <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
            state_q   <= S_WR_DATA;
          end
        end

        S_WR_DATA: begin
          if (bus.RX_D_VLD) begin
            rf_wr_data_q <= bus.RX_P_DATA;
            rf_wr_en_q   <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        S_RD_ADDR: begin
          if (bus.RX_D_VLD) begin
            rf_addr_q  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
            rf_rd_en_q <= 1'b1;
            state_q    <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (bus.RF_RD_DATA_VLD) begin
            rd_buf_q <= bus.RF_RD_DATA;
            state_q  <= S_TX_RD;
          end
        end

        S_ALU_A: begin
          if (bus.RX_D_VLD) begin
            rf_addr_q    <= ADDR_WIDTH'(0);
            rf_wr_data_q <= bus.RX_P_DATA;
            rf_wr_en_q   <= 1'b1;
            state_q      <= S_ALU_B;
          end
        end

        S_ALU_B: begin
          if (bus.RX_D_VLD) begin
            rf_addr_q    <= ADDR_WIDTH'(1);
            rf_wr_data_q <= bus.RX_P_DATA;
            rf_wr_en_q   <= 1'b1;
            state_q      <= S_ALU_FUN;
          end
        end

        S_ALU_FUN: begin
          if (bus.RX_D_VLD) begin
            alu_fun_q <= bus.RX_P_DATA[3:0];
            alu_en_q  <= 1'b1;
            state_q   <= S_ALU_WAIT;
          end
        end

        S_ALU_WAIT: begin
          if (bus.ALU_OUT_VLD) begin
            alu_res_q     <= bus.ALU_OUT;
            clk_gate_en_q <= 1'b0;
            state_q       <= S_TX_LO;
          end
        end

        // The three TX states share one handshake; tx_d_vld_q itself marks
        // whether we are still waiting for the line or waiting for acceptance.
        S_TX_LO, S_TX_HI, S_TX_RD: begin
          if (!tx_d_vld_q) begin
            if (!bus.TX_BUSY) begin
              tx_p_data_q <= tx_byte;
              tx_d_vld_q  <= 1'b1;
            end
          end else if (bus.TX_BUSY) begin
            tx_d_vld_q <= 1'b0;
            state_q    <= (state_q == S_TX_LO) ? S_TX_HI : S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.RF_ADDR     = rf_addr_q;
  assign bus.RF_WR_EN    = rf_wr_en_q;
  assign bus.RF_RD_EN    = rf_rd_en_q;
  assign bus.RF_WR_DATA  = rf_wr_data_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.CLK_GATE_EN = clk_gate_en_q;
  assign bus.TX_P_DATA   = tx_p_data_q;
  assign bus.TX_D_VLD    = tx_d_vld_q;

endmodule
